// File: rtl/seq_muldiv_if.sv
// Request/response bundle of the sequential multiply/divide unit.
// The requester drives start/op/a/b; the unit drives status and results.
interface seq_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/seq_muldiv.sv
// Radix-2 sequential multiplier/divider: MULT, MULTU, DIV, DIVU.
// Works on magnitudes in RUN and applies sign correction in FIX.
module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t state;

  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic             neg_q;
  logic             rneg_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             is_div;
  logic             sgn;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   add;
  logic [WIDTH:0]   mstep;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_f;
  logic [WIDTH-1:0] fix_hi;
  logic [WIDTH-1:0] fix_lo;

  always_comb begin
    is_div = op_q[1];
    sgn    = ~op_q[0];
    a_neg  = sgn & a_q[WIDTH-1];
    b_neg  = sgn & b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;

    // shift-add: sh holds the multiplier, low product bits shift in on top
    add    = {1'b0, acc} + {1'b0, m_q};
    mstep  = sh[0] ? add : {1'b0, acc};
    mul_hi = mstep[WIDTH:1];
    mul_lo = {mstep[0], sh[WIDTH-1:1]};

    // restoring divide: acc < m_q holds, so diff[WIDTH] is a clean borrow
    shl    = {acc, sh[WIDTH-1]};
    diff   = shl - {1'b0, m_q};
    fits   = ~diff[WIDTH];
    div_hi = fits ? diff[WIDTH-1:0] : shl[WIDTH-1:0];
    div_lo = {sh[WIDTH-2:0], fits};

    prod   = {acc, sh};
    prod_f = neg_q ? -prod : prod;
    fix_hi = prod_f[2*WIDTH-1:WIDTH];
    fix_lo = prod_f[WIDTH-1:0];
    if (is_div) begin
      fix_hi = rneg_q ? -acc : acc;
      fix_lo = neg_q ? -sh : sh;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      acc    <= '0;
      sh     <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_q   <= bus.op;
            a_q    <= bus.a;
            b_q    <= bus.b;
            dz_q   <= 1'b0;
            busy_q <= 1'b1;
            state  <= PREP;
          end
        end
        PREP: begin
          if (is_div && b_q == '0) begin
            dz_q   <= 1'b1;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            m_q    <= is_div ? b_mag : a_mag;
            sh     <= is_div ? a_mag : b_mag;
            acc    <= '0;
            cnt    <= CW'(WIDTH - 1);
            neg_q  <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            state  <= RUN;
          end
        end
        RUN: begin
          acc <= is_div ? div_hi : mul_hi;
          sh  <= is_div ? div_lo : mul_lo;
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv at WIDTH=32 and WIDTH=8.
// Expected values are hand-computed constants.
module tb_seq_muldiv;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_muldiv_if #(.WIDTH(32)) m32 ();
  seq_muldiv_if #(.WIDTH(8))  m8 ();

  seq_muldiv #(.WIDTH(32)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (m32.slave)
  );

  seq_muldiv #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (m8.slave)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op; optionally pulse a stray start at cycle poke.
  task automatic run32(input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input int poke,
                       output int lat, output logic dz1);
    @(negedge clk);
    m32.start = 1'b1;
    m32.op    = o;
    m32.a     = x;
    m32.b     = y;
    @(posedge clk);
    #1;
    m32.start = 1'b0;
    lat = 0;
    dz1 = 1'bx;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) dz1 = m32.div_zero;
      if (c == poke) begin
        m32.start = 1'b1;
        m32.op    = 2'b11;
        m32.a     = 32'd9;
        m32.b     = 32'd9;
      end
      if (c == poke + 1) m32.start = 1'b0;
      if (m32.done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check({tag, " done_pulse"}, {63'd0, m32.done}, 64'd0);
    check({tag, " busy_end"}, {63'd0, m32.busy}, 64'd0);
  endtask

  int   lat;
  logic dz1;
  int   dcount;

  initial begin
    m32.start = 1'b1;
    m32.op    = 2'b00;
    m32.a     = 32'd3;
    m32.b     = 32'd5;
    m8.start  = 1'b0;
    m8.op     = 2'b00;
    m8.a      = 8'd0;
    m8.b      = 8'd0;
    repeat (3) @(negedge clk);
    m32.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst busy", {63'd0, m32.busy}, 64'd0);
    check("rst done", {63'd0, m32.done}, 64'd0);
    check("rst dz", {63'd0, m32.div_zero}, 64'd0);
    check("rst hilo", {m32.hi, m32.lo}, 64'd0);

    run32(2'b00, 32'hFFFF_FFFD, 32'd7, 0, lat, dz1);
    check("mult lat", 64'(lat), 64'd35);
    check("mult res", {m32.hi, m32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    after_done("mult");
    check("mult hold", {m32.hi, m32.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, dz1);
    check("multu lat", 64'(lat), 64'd35);
    check("multu res", {m32.hi, m32.lo}, 64'hFFFF_FFFE_0000_0001);

    run32(2'b00, 32'h8000_0000, 32'h8000_0000, 0, lat, dz1);
    check("mult minmin", {m32.hi, m32.lo}, 64'h4000_0000_0000_0000);

    run32(2'b10, 32'hFFFF_FFF9, 32'd2, 0, lat, dz1);
    check("div lat", 64'(lat), 64'd35);
    check("div -7/2", {m32.hi, m32.lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    run32(2'b10, 32'd7, 32'hFFFF_FFFE, 0, lat, dz1);
    check("div 7/-2", {m32.hi, m32.lo}, 64'h0000_0001_FFFF_FFFD);

    run32(2'b11, 32'd100, 32'd7, 0, lat, dz1);
    check("divu 100/7", {m32.hi, m32.lo}, 64'h0000_0002_0000_000E);
    check("divu dz", {63'd0, m32.div_zero}, 64'd0);

    run32(2'b11, 32'd100, 32'd0, 0, lat, dz1);
    check("dz lat", 64'(lat), 64'd2);
    check("dz flag", {63'd0, m32.div_zero}, 64'd1);
    check("dz hold", {m32.hi, m32.lo}, 64'h0000_0002_0000_000E);
    after_done("dz");

    run32(2'b00, 32'd3, 32'd5, 0, lat, dz1);
    check("dz clear", {63'd0, dz1}, 64'd0);
    check("mult 3*5", {m32.hi, m32.lo}, 64'd15);

    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, dz1);
    check("div ovf", {m32.hi, m32.lo}, 64'h0000_0000_8000_0000);
    check("div ovf dz", {63'd0, m32.div_zero}, 64'd0);

    run32(2'b01, 32'd6, 32'd7, 5, lat, dz1);
    check("poke lat", 64'(lat), 64'd35);
    check("poke res", {m32.hi, m32.lo}, 64'd42);
    after_done("poke");

    @(negedge clk);
    m32.start = 1'b1;
    m32.op    = 2'b00;
    m32.a     = 32'd11;
    m32.b     = 32'd13;
    @(posedge clk);
    #1;
    m32.start = 1'b0;
    repeat (11) @(negedge clk);
    check("run busy", {63'd0, m32.busy}, 64'd1);
    reset = 1'b0;
    @(negedge clk);
    check("mid busy", {63'd0, m32.busy}, 64'd0);
    check("mid hilo", {m32.hi, m32.lo}, 64'd0);
    check("mid done", {63'd0, m32.done}, 64'd0);
    reset = 1'b1;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (m32.done) dcount++;
    end
    check("abandon", 64'(dcount), 64'd0);

    @(negedge clk);
    m8.start = 1'b1;
    m8.op    = 2'b00;
    m8.a     = 8'hFD;
    m8.b     = 8'd7;
    @(posedge clk);
    #1;
    m8.start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (m8.done) begin
        lat = c;
        break;
      end
    end
    check("w8 lat", 64'(lat), 64'd11);
    check("w8 res", {48'd0, m8.hi, m8.lo}, 64'hFFEB);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_muldiv.md
SEQ_MULDIV -- requirements
Module: seq_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; legal values are even and at least 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port hi  output  WIDTH  product upper half or remainder.
REQ-011 SHALL have port lo  output  WIDTH  product lower half or quotient.
REQ-012 SHALL have port div_zero  output  1  last division had a zero divisor.

Function
REQ-013 SHALL implement the FSM states IDLE, PREP, RUN, FIX and DONE.
REQ-014 SHALL accept a request at an edge where the state is IDLE and start=1, capturing a, b and op at that edge and moving to PREP.
REQ-015 SHALL ignore start, a, b and op in all states other than IDLE, including back-to-back start in DONE.
REQ-016 PREP SHALL form operand magnitudes and result sign for signed ops, load the iteration counter with WIDTH-1, and move to RUN.
REQ-017 PREP SHALL move directly to DONE when op is DIV or DIVU and the captured b is 0.
REQ-018 RUN SHALL perform one radix-2 step per cycle (shift-add for multiply, restoring subtract for divide) for exactly WIDTH cycles, then move to FIX.
REQ-019 FIX SHALL apply two's-complement sign correction and move to DONE.
REQ-020 DONE SHALL last exactly one cycle, drive done=1 and return to IDLE.
REQ-021 For a normal op, done SHALL be high in the (WIDTH+3)th cycle after the accepting edge (35 cycles when WIDTH=32).
REQ-022 For a zero divisor, done SHALL be high in the 2nd cycle after the accepting edge.
REQ-023 hi and lo SHALL be registered, SHALL update on the edge that enters DONE, and SHALL hold until the next update.
REQ-024 MULT and MULTU SHALL produce the full 2*WIDTH-bit product with {hi,lo} = a*b (signed for MULT, unsigned for MULTU).
REQ-025 DIV and DIVU SHALL set lo = quotient and hi = remainder.
REQ-026 DIV SHALL truncate the quotient toward zero and give the remainder the sign of the dividend.
REQ-027 DIV of the most-negative value by -1 SHALL return lo = most-negative value and hi = 0, with no flag raised.
REQ-028 For a zero divisor, hi and lo SHALL keep their previous values.
REQ-029 div_zero SHALL be set on entering DONE from a zero-divisor division and cleared on the next accepted start.
REQ-030 The iteration counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap inside RUN.

Reset
REQ-031 When reset=0 at a rising edge, in any state including mid-RUN, the block SHALL go to IDLE and set busy=0, done=0, div_zero=0, hi=0 and lo=0.
REQ-032 An operation in progress when reset is asserted SHALL be abandoned, with no done pulse.
REQ-033 When start=1 and reset=0 at the same edge, reset SHALL take priority and the request SHALL be dropped.

Verification
REQ-034 MULT with a=0xFFFFFFFD and b=7 SHALL produce done at accept+35, hi=0xFFFFFFFF and lo=0xFFFFFFEB.
REQ-035 MULTU with a=0xFFFFFFFF and b=0xFFFFFFFF SHALL produce hi=0xFFFFFFFE and lo=0x00000001.
REQ-036 DIV with a=0xFFFFFFF9 (-7) and b=2 SHALL produce lo=0xFFFFFFFD and hi=0xFFFFFFFF; DIVU with a=100 and b=7 SHALL produce lo=14 and hi=2.
REQ-037 DIVU with a=100 and b=0 SHALL produce done at accept+2, div_zero=1 and hi/lo unchanged; the next accepted MULT SHALL clear div_zero.
REQ-038 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL produce lo=0x80000000, hi=0 and div_zero=0.
REQ-039 start pulsed during RUN SHALL be ignored; reset=0 in RUN cycle 10 SHALL give busy=0 and hi=lo=0 next cycle with no done pulse; repeating REQ-034 at WIDTH=8 with a=0xFD and b=7 SHALL give done at accept+11 and {hi,lo}=0xFFEB.
